// File: rtl/ddr3_iod_train_pkg.sv
// Shared types and constants for DDR3 IOD per-bit read-delay training.
package ddr3_iod_train_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEL,
        ST_LOAD,
        ST_SETTLE,
        ST_CLR,
        ST_SAMPLE,
        ST_EVAL,
        ST_STEP,
        ST_CALC,
        ST_LOAD_ERR,
        ST_CTR,
        ST_STORE,
        ST_FIN
    } train_state_e;

    localparam int unsigned MOVE_GAP = 2;
    localparam logic        DIR_INC  = 1'b1;
    localparam logic        DIR_DEC  = 1'b0;

    // Delay-line command issued to the currently selected lane in the next cycle.
    typedef struct packed {
        logic move;
        logic dir;
        logic load;
        logic clr;
    } lane_cmd_t;

endpackage

// File: rtl/ddr3_iod_dly_train_if.sv
// Sequencer control and IOD lane delay/eye-monitor signals of the read-delay trainer.
interface ddr3_iod_dly_train_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned TAP_W     = 8
);
    logic                         start;
    logic [NUM_LANES-1:0]         lane_mask;
    logic [NUM_LANES-1:0]         eye_monitor_early;
    logic [NUM_LANES-1:0]         eye_monitor_late;
    logic [NUM_LANES-1:0]         delay_line_out_of_range;
    logic [NUM_LANES-1:0]         delay_line_move;
    logic [NUM_LANES-1:0]         delay_line_direction;
    logic [NUM_LANES-1:0]         delay_line_load;
    logic [NUM_LANES-1:0]         eye_monitor_clear_flags;
    logic                         busy;
    logic                         done;
    logic [NUM_LANES-1:0]         lane_err;
    logic [NUM_LANES*TAP_W-1:0]   tap_val;

    modport master (
        output start, lane_mask, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
        input  delay_line_move, delay_line_direction, delay_line_load, eye_monitor_clear_flags,
               busy, done, lane_err, tap_val
    );

    modport slave (
        input  start, lane_mask, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
        output delay_line_move, delay_line_direction, delay_line_load, eye_monitor_clear_flags,
               busy, done, lane_err, tap_val
    );
endinterface

// File: rtl/ddr3_iod_eye_sampler.sv
// Accumulates EARLY|LATE of the selected lane over one sample window after a clear,
// then returns a registered one-cycle pass/fail strobe.
module ddr3_iod_eye_sampler #(
    parameter int unsigned SAMPLE_CYC = 16
) (
    input  logic fab_clk,
    input  logic arst_n,
    input  logic clear,
    input  logic early,
    input  logic late,
    output logic last_c,
    output logic pass,
    output logic valid
);
    localparam int unsigned CNT_W = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic             seen_q;

    assign last_c = active_q && (cnt_q == CNT_W'(SAMPLE_CYC - 1));

    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            pass     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clear) begin
                active_q <= 1'b1;
                cnt_q    <= '0;
                seen_q   <= 1'b0;
            end else if (active_q) begin
                if (last_c) begin
                    active_q <= 1'b0;
                    valid    <= 1'b1;
                    pass     <= !(seen_q | early | late);
                end else begin
                    cnt_q  <= cnt_q + CNT_W'(1);
                    seen_q <= seen_q | early | late;
                end
            end
        end
    end
endmodule

// File: rtl/ddr3_iod_dly_train.sv
// Per-bit DDR3 read-delay trainer: sweeps each unmasked lane's delay line, finds the first
// passing tap window and centres the delay in it, one lane at a time.
module ddr3_iod_dly_train
    import ddr3_iod_train_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned TAP_W      = 8,
    parameter int unsigned MAX_TAPS   = 128,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned SAMPLE_CYC = 16
) (
    input logic                fab_clk,
    input logic                arst_n,
    ddr3_iod_dly_train_if.slave bus
);
    localparam int unsigned LANE_W = $clog2(NUM_LANES + 1);
    localparam int unsigned LIDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned GAP_W  = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;

    train_state_e               state_q, state_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [TAP_W-1:0]           cur_tap_q, cur_tap_d;
    logic [TAP_W-1:0]           first_q, first_d;
    logic [TAP_W-1:0]           last_q, last_d;
    logic [TAP_W-1:0]           target_q, target_d;
    logic                       seen_q, seen_d;
    logic [SET_W-1:0]           settle_q, settle_d;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic [NUM_LANES-1:0]       mask_q, mask_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [NUM_LANES-1:0]       err_q, err_d;
    logic [NUM_LANES*TAP_W-1:0] tap_val_q, tap_val_d;
    logic [NUM_LANES-1:0]       move_q, move_d;
    logic [NUM_LANES-1:0]       dir_q, dir_d;
    logic [NUM_LANES-1:0]       load_q, load_d;
    logic [NUM_LANES-1:0]       clr_q, clr_d;

    logic [LIDX_W-1:0]    lane_idx;
    logic [NUM_LANES-1:0] lane_oh;
    lane_cmd_t            cmd;
    logic                 sel_found;
    logic [LANE_W-1:0]    sel_lane;
    logic                 smp_last_c;
    logic                 smp_pass;
    logic                 smp_valid;

    assign lane_idx = LIDX_W'(lane_q);

    ddr3_iod_eye_sampler #(.SAMPLE_CYC(SAMPLE_CYC)) u_sampler (
        .fab_clk (fab_clk),
        .arst_n  (arst_n),
        .clear   (state_q == ST_CLR),
        .early   (bus.eye_monitor_early[lane_idx]),
        .late    (bus.eye_monitor_late[lane_idx]),
        .last_c  (smp_last_c),
        .pass    (smp_pass),
        .valid   (smp_valid)
    );

    // Lowest unmasked lane at or above the lane counter.
    always_comb begin
        sel_found = 1'b0;
        sel_lane  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (!sel_found && mask_q[i] && (LANE_W'(i) >= lane_q)) begin
                sel_found = 1'b1;
                sel_lane  = LANE_W'(i);
            end
        end
    end

    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_IDLE;
            lane_q    <= '0;
            cur_tap_q <= '0;
            first_q   <= '0;
            last_q    <= '0;
            target_q  <= '0;
            seen_q    <= 1'b0;
            settle_q  <= '0;
            gap_q     <= '0;
            mask_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            tap_val_q <= '0;
            move_q    <= '0;
            dir_q     <= '0;
            load_q    <= '0;
            clr_q     <= '0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            cur_tap_q <= cur_tap_d;
            first_q   <= first_d;
            last_q    <= last_d;
            target_q  <= target_d;
            seen_q    <= seen_d;
            settle_q  <= settle_d;
            gap_q     <= gap_d;
            mask_q    <= mask_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tap_val_q <= tap_val_d;
            move_q    <= move_d;
            dir_q     <= dir_d;
            load_q    <= load_d;
            clr_q     <= clr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        cur_tap_d = cur_tap_q;
        first_d   = first_q;
        last_d    = last_q;
        target_d  = target_q;
        seen_d    = seen_q;
        settle_d  = settle_q;
        gap_d     = gap_q;
        mask_d    = mask_q;
        done_d    = done_q;
        err_d     = err_q;
        tap_val_d = tap_val_q;
        cmd       = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_SEL;
                    lane_d    = '0;
                    mask_d    = bus.lane_mask;
                    done_d    = 1'b0;
                    err_d     = '0;
                    tap_val_d = '0;
                end
            end
            ST_SEL: begin
                if (sel_found) begin
                    lane_d  = sel_lane;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_LOAD: begin
                cur_tap_d = '0;
                first_d   = '0;
                last_d    = '0;
                seen_d    = 1'b0;
                settle_d  = '0;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYC - 1)) state_d = ST_CLR;
                else                                     settle_d = settle_q + SET_W'(1);
            end
            ST_CLR: state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (smp_last_c) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (smp_valid && smp_pass) begin
                    last_d = cur_tap_q;
                    if (!seen_q) begin
                        first_d = cur_tap_q;
                        seen_d  = 1'b1;
                    end
                end
                // A passing tap that also hits the range limit is kept, then the window closes.
                if ((seen_q && !(smp_valid && smp_pass)) ||
                    (cur_tap_q == TAP_W'(MAX_TAPS - 1)) ||
                    bus.delay_line_out_of_range[lane_idx])
                    state_d = ST_CALC;
                else
                    state_d = ST_STEP;
            end
            ST_STEP: begin
                cur_tap_d = cur_tap_q + TAP_W'(1);
                settle_d  = '0;
                state_d   = ST_SETTLE;
            end
            ST_CALC: begin
                gap_d = '0;
                if (!seen_q) begin
                    err_d[lane_idx] = 1'b1;
                    target_d        = '0;
                    state_d         = ST_LOAD_ERR;
                end else begin
                    target_d = first_q + ((last_q - first_q) >> 1);
                    state_d  = ST_CTR;
                end
            end
            ST_LOAD_ERR: begin
                cur_tap_d = '0;
                state_d   = ST_STORE;
            end
            ST_CTR: begin
                if (cur_tap_q > target_q) begin
                    gap_d = (gap_q == GAP_W'(MOVE_GAP - 1)) ? '0 : gap_q + GAP_W'(1);
                    if (gap_q == '0) begin
                        cmd.move  = 1'b1;
                        cmd.dir   = DIR_DEC;
                        cur_tap_d = cur_tap_q - TAP_W'(1);
                    end
                end else begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                tap_val_d[lane_idx*TAP_W +: TAP_W] = cur_tap_q;
                lane_d  = lane_q + LANE_W'(1);
                state_d = ST_SEL;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Pulses are registered, so they are decoded from the state being entered.
        if (state_d == ST_STEP) begin
            cmd.move = 1'b1;
            cmd.dir  = DIR_INC;
        end
        cmd.load = (state_d == ST_LOAD) || (state_d == ST_LOAD_ERR);
        cmd.clr  = (state_d == ST_CLR);

        if (state_d == ST_FIN) done_d = 1'b1;
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_FIN);
        lane_oh = NUM_LANES'(1) << lane_d;
        move_d  = cmd.move ? lane_oh : '0;
        dir_d   = (cmd.move && (cmd.dir == DIR_INC)) ? lane_oh : '0;
        load_d  = cmd.load ? lane_oh : '0;
        clr_d   = cmd.clr ? lane_oh : '0;
    end

    assign bus.delay_line_move         = move_q;
    assign bus.delay_line_direction    = dir_q;
    assign bus.delay_line_load         = load_q;
    assign bus.eye_monitor_clear_flags = clr_q;
    assign bus.busy                    = busy_q;
    assign bus.done                    = done_q;
    assign bus.lane_err                = err_q;
    assign bus.tap_val                 = tap_val_q;
endmodule

// File: tb/tb_ddr3_iod_dly_train.sv
// Directed bench for ddr3_iod_dly_train with a behavioural IOD delay-line/eye model and a
// per-lane expected-result scoreboard checked at each DONE.
module tb_ddr3_iod_dly_train;
    localparam int unsigned NL = 4;
    localparam int unsigned TW = 8;
    localparam int          NEVER = 1000;

    logic fab_clk = 1'b0;
    logic arst_n  = 1'b0;
    always #5 fab_clk = ~fab_clk;

    ddr3_iod_dly_train_if #(.NUM_LANES(NL), .TAP_W(TW)) io ();

    ddr3_iod_dly_train #(
        .NUM_LANES(NL), .TAP_W(TW), .MAX_TAPS(128), .SETTLE_CYC(8), .SAMPLE_CYC(16)
    ) dut (
        .fab_clk (fab_clk),
        .arst_n  (arst_n),
        .bus     (io)
    );

    // IOD model: eye window [lo,hi] per lane, range limit at taps >= oor_at.
    int lo[NL];
    int hi[NL];
    int oor_at[NL];
    int phys[NL];
    int inc_n[NL];
    int dec_n[NL];
    int load_n[NL];
    int clr_n[NL];
    int load_order[$];
    logic cnt_clr = 1'b0;

    logic [NL-1:0] e_v, l_v, o_v;
    always_comb begin
        e_v = '0;
        l_v = '0;
        o_v = '0;
        for (int i = 0; i < NL; i++) begin
            if (!(phys[i] >= lo[i] && phys[i] <= hi[i])) begin
                if (phys[i] < lo[i]) e_v[i] = 1'b1;
                else                 l_v[i] = 1'b1;
            end
            o_v[i] = (phys[i] >= oor_at[i]);
        end
    end
    assign io.eye_monitor_early       = e_v;
    assign io.eye_monitor_late        = l_v;
    assign io.delay_line_out_of_range = o_v;

    always @(posedge fab_clk) begin
        for (int i = 0; i < NL; i++) begin
            if (io.delay_line_load[i])      phys[i] <= 0;
            else if (io.delay_line_move[i]) phys[i] <= io.delay_line_direction[i] ? phys[i] + 1 : phys[i] - 1;
        end
        if (cnt_clr) begin
            for (int i = 0; i < NL; i++) begin
                inc_n[i] <= 0; dec_n[i] <= 0; load_n[i] <= 0; clr_n[i] <= 0;
            end
            load_order.delete();
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (io.delay_line_move[i] &&  io.delay_line_direction[i]) inc_n[i] <= inc_n[i] + 1;
                if (io.delay_line_move[i] && !io.delay_line_direction[i]) dec_n[i] <= dec_n[i] + 1;
                if (io.delay_line_load[i]) begin
                    load_n[i] <= load_n[i] + 1;
                    if (load_n[i] == 0) load_order.push_back(i);
                end
                if (io.eye_monitor_clear_flags[i]) clr_n[i] <= clr_n[i] + 1;
            end
        end
    end

    typedef struct {
        string tag;
        int lane, tap, err, inc, dec, loads, clrs;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Trained lane: sweep stops at end_tap, centre is first+(last-first)/2, then walk back down.
    task automatic push_trained(input string tag, input int lane, input int first, input int last,
                                input int end_tap);
        exp_t e;
        e.tag = tag; e.lane = lane; e.tap = first + (last - first) / 2; e.err = 0;
        e.inc = end_tap; e.dec = end_tap - e.tap; e.loads = 1; e.clrs = end_tap + 1;
        sb.push_back(e);
    endtask

    task automatic push_err(input string tag, input int lane, input int end_tap);
        exp_t e;
        e.tag = tag; e.lane = lane; e.tap = 0; e.err = 1;
        e.inc = end_tap; e.dec = 0; e.loads = 2; e.clrs = end_tap + 1;
        sb.push_back(e);
    endtask

    task automatic push_skip(input string tag, input int lane);
        exp_t e;
        e.tag = tag; e.lane = lane; e.tap = 0; e.err = 0;
        e.inc = 0; e.dec = 0; e.loads = 0; e.clrs = 0;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s.l%0d.tap_val", e.tag, e.lane), 32'(io.tap_val[e.lane*TW +: TW]), e.tap);
            check($sformatf("%s.l%0d.lane_err", e.tag, e.lane), 32'(io.lane_err[e.lane]), e.err);
            check($sformatf("%s.l%0d.inc_moves", e.tag, e.lane), inc_n[e.lane], e.inc);
            check($sformatf("%s.l%0d.dec_moves", e.tag, e.lane), dec_n[e.lane], e.dec);
            check($sformatf("%s.l%0d.loads", e.tag, e.lane), load_n[e.lane], e.loads);
            check($sformatf("%s.l%0d.clears", e.tag, e.lane), clr_n[e.lane], e.clrs);
            if (e.loads != 0)
                check($sformatf("%s.l%0d.phys_tap", e.tag, e.lane), phys[e.lane], e.tap);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},  32'(io.busy), 0);
        check({tag, ".done"},  32'(io.done), 0);
        check({tag, ".move"},  32'(io.delay_line_move), 0);
        check({tag, ".dir"},   32'(io.delay_line_direction), 0);
        check({tag, ".load"},  32'(io.delay_line_load), 0);
        check({tag, ".clear"}, 32'(io.eye_monitor_clear_flags), 0);
        check({tag, ".err"},   32'(io.lane_err), 0);
        check({tag, ".tap"},   32'(io.tap_val), 0);
    endtask

    task automatic clear_counts();
        @(negedge fab_clk); cnt_clr = 1'b1;
        @(negedge fab_clk); cnt_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [NL-1:0] mask);
        @(negedge fab_clk); io.start = 1'b1; io.lane_mask = mask;
        @(negedge fab_clk); io.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (io.done !== 1'b1 && c < 20000) begin
            @(posedge fab_clk); #1; c++;
        end
        check({tag, ".done"}, 32'(io.done), 1);
        check({tag, ".busy"}, 32'(io.busy), 0);
    endtask

    task automatic wait_clr(input int lane, input int n, input string tag);
        int c = 0;
        while (clr_n[lane] < n && c < 5000) begin
            @(negedge fab_clk); c++;
        end
        check(tag, 32'(clr_n[lane] >= n), 1);
    endtask

    task automatic run(input string tag, input logic [NL-1:0] mask);
        clear_counts();
        pulse_start(mask);
        check({tag, ".done_cleared"}, 32'(io.done), 0);
        check({tag, ".busy_set"}, 32'(io.busy), 1);
        wait_done(tag);
        pop_check();
    endtask

    task automatic set_eye(input int lane, input int l, input int h);
        lo[lane] = l; hi[lane] = h;
    endtask

    int pulses_before;

    initial begin
        io.start = 1'b0;
        io.lane_mask = '0;
        for (int i = 0; i < NL; i++) begin
            lo[i] = NEVER; hi[i] = -1; oor_at[i] = NEVER;
        end

        // Reset state
        repeat (3) @(negedge fab_clk);
        check_all_zero("reset");
        arst_n = 1'b1;

        // Empty mask: DONE two edges after START
        @(negedge fab_clk); io.start = 1'b1; io.lane_mask = '0;
        @(posedge fab_clk); #1; io.start = 1'b0;
        check("empty.e1.done", 32'(io.done), 0);
        check("empty.e1.busy", 32'(io.busy), 1);
        @(posedge fab_clk); #1;
        check("empty.e2.done", 32'(io.done), 1);
        check("empty.e2.busy", 32'(io.busy), 0);
        @(posedge fab_clk); #1;
        check("empty.e3.done_level", 32'(io.done), 1);

        // T1: single eye 20..40, sweep ends on the failing tap 41
        set_eye(0, 20, 40);
        push_trained("t1", 0, 20, 40, 41);
        for (int i = 1; i < NL; i++) push_skip("t1", i);
        run("t1", 4'b0001);

        // T2: even-width eye 10..13, sweep ends at 14
        set_eye(0, 10, 13);
        push_trained("t2", 0, 10, 13, 14);
        for (int i = 1; i < NL; i++) push_skip("t2", i);
        run("t2", 4'b0001);

        // T3: no eye, full sweep to the last tap then error reload
        set_eye(0, NEVER, -1);
        push_err("t3", 0, 127);
        for (int i = 1; i < NL; i++) push_skip("t3", i);
        run("t3", 4'b0001);

        // T4: masked lanes 0 and 2 untouched even though they have eyes
        set_eye(0, 20, 30);
        set_eye(1, 5, 9);
        set_eye(2, 20, 30);
        set_eye(3, 2, 6);
        push_skip("t4", 0);
        push_trained("t4", 1, 5, 9, 10);
        push_skip("t4", 2);
        push_trained("t4", 3, 2, 6, 7);
        run("t4", 4'b1010);
        check("t4.order_len", load_order.size(), 2);
        if (load_order.size() == 2) begin
            check("t4.order0", load_order[0], 1);
            check("t4.order1", load_order[1], 3);
        end

        // T5: range limit at tap 50 inside a wider eye; tap 50 still counts
        set_eye(0, 40, 90);
        oor_at[0] = 50;
        push_trained("t5", 0, 40, 50, 50);
        for (int i = 1; i < NL; i++) push_skip("t5", i);
        run("t5", 4'b0001);
        oor_at[0] = NEVER;

        // T6: START while busy ignored, reset mid-SAMPLE, then a clean retrain
        set_eye(2, 3, 7);
        clear_counts();
        pulse_start(4'b0100);
        wait_clr(2, 3, "t6.reach_tap2");
        pulse_start(4'b0001);
        repeat (3) @(negedge fab_clk);
        check("t6.busy_start_busy", 32'(io.busy), 1);
        check("t6.no_reload_l2", load_n[2], 1);
        check("t6.no_load_l0", load_n[0], 0);
        wait_clr(2, 4, "t6.reach_tap3");
        repeat (4) @(negedge fab_clk);
        arst_n = 1'b0;
        #1;
        check_all_zero("t6.rst");
        pulses_before = 0;
        for (int i = 0; i < NL; i++)
            pulses_before += inc_n[i] + dec_n[i] + load_n[i] + clr_n[i];
        repeat (3) @(negedge fab_clk);
        check("t6.quiet_in_reset", inc_n[2] + dec_n[2] + load_n[2] + clr_n[2]
              + inc_n[0] + load_n[0], pulses_before - inc_n[1] - dec_n[1] - load_n[1] - clr_n[1]
              - inc_n[3] - dec_n[3] - load_n[3] - clr_n[3] - dec_n[0] - clr_n[0]);
        arst_n = 1'b1;
        repeat (5) @(negedge fab_clk);
        check("t6.idle_after_reset", 32'(io.busy), 0);
        check("t6.no_pulse_after_reset",
              inc_n[0] + dec_n[0] + load_n[0] + clr_n[0] + inc_n[1] + dec_n[1] + load_n[1] + clr_n[1] +
              inc_n[2] + dec_n[2] + load_n[2] + clr_n[2] + inc_n[3] + dec_n[3] + load_n[3] + clr_n[3],
              pulses_before);
        push_skip("t6", 0);
        push_skip("t6", 1);
        push_trained("t6", 2, 3, 7, 8);
        push_skip("t6", 3);
        run("t6", 4'b0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
